// File: rtl/rsa_pkg.sv
// Shared types for the RSA-256 exponent scheduler: operand width, counter width, FSM states.
// Pure declarations, no timing or flow-control behaviour.
package rsa_pkg;
    localparam int W     = 256;
    localparam int CNT_W = $clog2(W) + 1;

    typedef logic [W-1:0]     word_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } sched_state_t;

    localparam cnt_t CNT_LAST = cnt_t'(W - 1);
endpackage

// File: rtl/rsa_exp_scheduler.sv
// Right-to-left square-and-multiply sequencer: a^e mod n over one ModuloProduct and two Montgomery units.
// Latency ~mp_lat + W*(mont_lat+3); src_rdy only in IDLE, result held until result_rdy. RSA_EARLY_EXIT_EN stops at e's MSB.
module rsa_exp_scheduler
    import rsa_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         src_val,
    output logic         src_rdy,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_e,
    input  logic [W-1:0] i_n,
    output logic         result_val,
    input  logic         result_rdy,
    output logic [W-1:0] o_a_pow_e,
    output logic         mp_start,
    output logic [W-1:0] mp_a,
    output logic [W-1:0] mp_n,
    input  logic         mp_finish,
    input  logic [W-1:0] mp_result,
    output logic         mc_start,
    output logic [W-1:0] mc_a,
    output logic [W-1:0] mc_b,
    input  logic         mc_finish,
    input  logic [W-1:0] mc_result,
    output logic         ms_start,
    output logic [W-1:0] ms_a,
    output logic [W-1:0] ms_b,
    input  logic         ms_finish,
    input  logic [W-1:0] ms_result
);

    sched_state_t state_q, state_d;
    word_t        e_q, e_d, n_q, n_d, m_q, m_d, t_q, t_d;
    word_t        mc_res_q, mc_res_d, ms_res_q, ms_res_d, out_q, out_d;
    cnt_t         cnt_q, cnt_d;
    logic         c_done_q, c_done_d, s_done_q, s_done_d;
    logic         src_rdy_q, src_rdy_d, result_val_q, result_val_d;
    logic         mp_start_q, mp_start_d, mc_start_q, mc_start_d, ms_start_q, ms_start_d;
    logic         last_iter;

    always_comb begin
        state_d      = state_q;
        e_d          = e_q;
        n_d          = n_q;
        m_d          = m_q;
        t_d          = t_q;
        mc_res_d     = mc_res_q;
        ms_res_d     = ms_res_q;
        out_d        = out_q;
        cnt_d        = cnt_q;
        c_done_d     = c_done_q;
        s_done_d     = s_done_q;
        src_rdy_d    = src_rdy_q;
        result_val_d = result_val_q;
        mp_start_d   = 1'b0;
        mc_start_d   = 1'b0;
        ms_start_d   = 1'b0;
        last_iter    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // t holds the raw base until ModuloProduct returns its converted form
                if (src_val && src_rdy_q) begin
                    t_d        = i_a;
                    e_d        = i_e;
                    n_d        = i_n;
                    mp_start_d = 1'b1;
                    src_rdy_d  = 1'b0;
                    state_d    = S_PREP;
                end
            end
            S_PREP: begin
                if (mp_finish) begin
                    t_d     = mp_result;
                    m_d     = word_t'(1);
                    cnt_d   = '0;
                    state_d = S_ISSUE;
`ifdef RSA_EARLY_EXIT_EN
                    if (e_q == '0) begin
                        out_d        = word_t'(1);
                        result_val_d = 1'b1;
                        state_d      = S_DONE;
                    end
`endif
                end
            end
            S_ISSUE: begin
                ms_start_d = 1'b1;
                mc_start_d = e_q[0];
                c_done_d   = !e_q[0];
                s_done_d   = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A set done flag masks later pulses, so stray finishes cannot overwrite a result
                if (mc_finish && !c_done_q) begin
                    c_done_d = 1'b1;
                    mc_res_d = mc_result;
                end
                if (ms_finish && !s_done_q) begin
                    s_done_d = 1'b1;
                    ms_res_d = ms_result;
                end
                if (c_done_q && s_done_q) begin
                    t_d = ms_res_q;
                    if (e_q[0]) begin
                        m_d = mc_res_q;
                    end
                    e_d       = e_q >> 1;
                    cnt_d     = cnt_q + 1'b1;
                    last_iter = (cnt_q == CNT_LAST);
`ifdef RSA_EARLY_EXIT_EN
                    last_iter = last_iter || (e_d == '0);
`endif
                    if (last_iter) begin
                        out_d        = m_d;
                        result_val_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (result_rdy) begin
                    result_val_d = 1'b0;
                    src_rdy_d    = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                src_rdy_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            e_q          <= '0;
            n_q          <= '0;
            m_q          <= '0;
            t_q          <= '0;
            mc_res_q     <= '0;
            ms_res_q     <= '0;
            out_q        <= '0;
            cnt_q        <= '0;
            c_done_q     <= 1'b0;
            s_done_q     <= 1'b0;
            src_rdy_q    <= 1'b1;
            result_val_q <= 1'b0;
            mp_start_q   <= 1'b0;
            mc_start_q   <= 1'b0;
            ms_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_q          <= e_d;
            n_q          <= n_d;
            m_q          <= m_d;
            t_q          <= t_d;
            mc_res_q     <= mc_res_d;
            ms_res_q     <= ms_res_d;
            out_q        <= out_d;
            cnt_q        <= cnt_d;
            c_done_q     <= c_done_d;
            s_done_q     <= s_done_d;
            src_rdy_q    <= src_rdy_d;
            result_val_q <= result_val_d;
            mp_start_q   <= mp_start_d;
            mc_start_q   <= mc_start_d;
            ms_start_q   <= ms_start_d;
        end
    end

    assign src_rdy    = src_rdy_q;
    assign result_val = result_val_q;
    assign o_a_pow_e  = out_q;
    assign mp_start   = mp_start_q;
    assign mp_a       = t_q;
    assign mp_n       = n_q;
    assign mc_start   = mc_start_q;
    assign mc_a       = m_q;
    assign mc_b       = t_q;
    assign ms_start   = ms_start_q;
    assign ms_a       = t_q;
    assign ms_b       = t_q;

endmodule
